// File: rtl/game_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | game_sequencer : round state, lives/score/level, movement tick, fire arb |
// | Rev 1.0                                                                  |
// +------------------------------------------------------------------------+
module game_sequencer #(
    parameter int TICK_DIV      = 1048576,
    parameter int FIRE_COOLDOWN = 8,
    parameter int START_LIVES   = 3,
    parameter int HIT_FREEZE    = 16
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Start,
    input  logic       Fire_Btn,
    input  logic       Alien_Hit,
    input  logic       Player_Hit,
    input  logic       Aliens_Defeated,
    input  logic       Reached_Bottom,
    input  logic       Bullet_Onscreen,
    output logic       Game_Tick,
    output logic       Bullet_Fired,
    output logic       Round_Reset,
    output logic [1:0] State,
    output logic [1:0] Lives,
    output logic [9:0] Score,
    output logic [2:0] Level
);

    localparam int              PW          = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]   C_TICK_MAX  = PW'(TICK_DIV - 1);
    localparam logic [3:0]      C_COOLDOWN  = 4'(FIRE_COOLDOWN);
    localparam logic [7:0]      C_FREEZE    = 8'(HIT_FREEZE);
    localparam logic [1:0]      C_LIVES     = 2'(START_LIVES);
    localparam logic [9:0]      C_SCORE_MAX = 10'd999;
    localparam logic [2:0]      C_LEVEL_MAX = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_PLAY = 2'b01,
        ST_WIN  = 2'b10,
        ST_LOSE = 2'b11
    } state_t;

    logic          start_s1_q, start_s2_q, start_s3_q;
    logic          start_s1_d, start_s2_d, start_s3_d;
    logic          fire_s1_q, fire_s2_q, fire_s3_q;
    logic          fire_s1_d, fire_s2_d, fire_s3_d;
    logic [1:0]    valid_q, valid_d;
    logic          armed_q, armed_d;
    logic [PW-1:0] presc_q, presc_d;
    state_t        state_q, state_d;
    logic [1:0]    lives_q, lives_d;
    logic [9:0]    score_q, score_d;
    logic [2:0]    level_q, level_d;
    logic [7:0]    freeze_q, freeze_d;
    logic [3:0]    cool_q, cool_d;
    logic          pend_q, pend_d;
    logic          game_tick_q, game_tick_d;
    logic          fired_q, fired_d;
    logic          round_reset_q, round_reset_d;

    logic w_tick;
    logic w_start_edge;
    logic w_fire_edge;
    logic w_want;
    logic w_grant;
    logic w_loss;

    assign w_tick       = (presc_q == C_TICK_MAX);
    // Start only counts once a genuine low sample has passed through the
    // synchroniser, so a switch already on at reset release is not an edge.
    assign w_start_edge = armed_q & start_s2_q & ~start_s3_q;
    assign w_fire_edge  = fire_s2_q & ~fire_s3_q;
    assign w_want       = pend_q | w_fire_edge;
    assign w_grant      = (state_q == ST_PLAY) & w_want & (freeze_q == 8'd0)
                        & (cool_q == 4'd0) & ~Bullet_Onscreen;
    assign w_loss       = Reached_Bottom
                        | (Player_Hit & (freeze_q == 8'd0) & (lives_q <= 2'd1));

    always_comb begin
        start_s1_d    = Start;
        start_s2_d    = start_s1_q;
        start_s3_d    = start_s2_q;
        fire_s1_d     = Fire_Btn;
        fire_s2_d     = fire_s1_q;
        fire_s3_d     = fire_s2_q;
        valid_d       = {valid_q[0], 1'b1};
        armed_d       = armed_q | (valid_q[1] & ~start_s2_q);
        presc_d       = w_tick ? '0 : presc_q + PW'(1);
        state_d       = state_q;
        lives_d       = lives_q;
        score_d       = score_q;
        level_d       = level_q;
        freeze_d      = (w_tick && freeze_q != 8'd0) ? freeze_q - 8'd1 : freeze_q;
        cool_d        = (w_tick && cool_q != 4'd0) ? cool_q - 4'd1 : cool_q;
        pend_d        = 1'b0;
        game_tick_d   = w_tick & (state_q == ST_PLAY) & (freeze_q == 8'd0);
        fired_d       = 1'b0;
        round_reset_d = 1'b0;

        case (state_q)
            ST_IDLE, ST_LOSE: begin
                if (w_start_edge) begin
                    state_d       = ST_PLAY;
                    round_reset_d = 1'b1;
                    lives_d       = C_LIVES;
                    score_d       = 10'd0;
                    level_d       = 3'd0;
                    freeze_d      = 8'd0;
                    cool_d        = 4'd0;
                end
            end
            ST_WIN: begin
                if (w_start_edge) begin
                    state_d       = ST_PLAY;
                    round_reset_d = 1'b1;
                    if (level_q != C_LEVEL_MAX) begin
                        level_d = level_q + 3'd1;
                    end
                end
            end
            ST_PLAY: begin
                if (Alien_Hit && score_q != C_SCORE_MAX) begin
                    score_d = score_q + 10'd1;
                end
                pend_d = w_want;
                if (w_grant) begin
                    fired_d = 1'b1;
                    pend_d  = 1'b0;
                    cool_d  = C_COOLDOWN;
                end
                if (w_loss) begin
                    state_d = ST_LOSE;
                    lives_d = 2'd0;
                    pend_d  = 1'b0;
                end else begin
                    if (Player_Hit && freeze_q == 8'd0) begin
                        lives_d  = lives_q - 2'd1;
                        freeze_d = C_FREEZE;
                    end
                    if (Aliens_Defeated) begin
                        state_d = ST_WIN;
                        pend_d  = 1'b0;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            start_s1_q    <= 1'b0;
            start_s2_q    <= 1'b0;
            start_s3_q    <= 1'b0;
            fire_s1_q     <= 1'b0;
            fire_s2_q     <= 1'b0;
            fire_s3_q     <= 1'b0;
            valid_q       <= 2'b00;
            armed_q       <= 1'b0;
            presc_q       <= '0;
            state_q       <= ST_IDLE;
            lives_q       <= 2'd0;
            score_q       <= 10'd0;
            level_q       <= 3'd0;
            freeze_q      <= 8'd0;
            cool_q        <= 4'd0;
            pend_q        <= 1'b0;
            game_tick_q   <= 1'b0;
            fired_q       <= 1'b0;
            round_reset_q <= 1'b0;
        end else begin
            start_s1_q    <= start_s1_d;
            start_s2_q    <= start_s2_d;
            start_s3_q    <= start_s3_d;
            fire_s1_q     <= fire_s1_d;
            fire_s2_q     <= fire_s2_d;
            fire_s3_q     <= fire_s3_d;
            valid_q       <= valid_d;
            armed_q       <= armed_d;
            presc_q       <= presc_d;
            state_q       <= state_d;
            lives_q       <= lives_d;
            score_q       <= score_d;
            level_q       <= level_d;
            freeze_q      <= freeze_d;
            cool_q        <= cool_d;
            pend_q        <= pend_d;
            game_tick_q   <= game_tick_d;
            fired_q       <= fired_d;
            round_reset_q <= round_reset_d;
        end
    end

    assign Game_Tick    = game_tick_q;
    assign Bullet_Fired = fired_q;
    assign Round_Reset  = round_reset_q;
    assign State        = state_q;
    assign Lives        = lives_q;
    assign Score        = score_q;
    assign Level        = level_q;

endmodule
`default_nettype wire

// File: tb/tb_game_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_game_sequencer : vector table, corner sequences, random rule model    |
// | Rev 1.0                                                                  |
// +------------------------------------------------------------------------+
module tb_game_sequencer;

    localparam int TD = 4;
    localparam int FC = 2;
    localparam int SL = 3;
    localparam int HF = 2;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0, fire = 1'b0, ah = 1'b0, ph = 1'b0;
    logic       ad = 1'b0, rb = 1'b0, bo = 1'b0;
    logic       gt, bf, rr;
    logic [1:0] st, lv;
    logic [9:0] sc;
    logic [2:0] lvl;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    game_sequencer #(
        .TICK_DIV(TD), .FIRE_COOLDOWN(FC), .START_LIVES(SL), .HIT_FREEZE(HF)
    ) dut (
        .Clk(clk), .Reset(rst_n), .Start(start), .Fire_Btn(fire),
        .Alien_Hit(ah), .Player_Hit(ph), .Aliens_Defeated(ad),
        .Reached_Bottom(rb), .Bullet_Onscreen(bo),
        .Game_Tick(gt), .Bullet_Fired(bf), .Round_Reset(rr),
        .State(st), .Lives(lv), .Score(sc), .Level(lvl)
    );

    task automatic check(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- reference model (game rules, edge-count based) -------
    int m_n = 0, m_st = 0, m_lives = 0, m_score = 0, m_level = 0, m_frz = 0, m_cd = 0;
    bit m_pend = 0, m_gt = 0, m_bf = 0, m_rr = 0;
    bit sq[$];
    bit fq[$];

    task automatic model_step();
        bit tick, s_edge, f_edge, want;
        int st0, fr0, cd0, lv0;
        m_n++;
        tick   = (m_n % TD) == 0;
        s_edge = 0;
        f_edge = 0;
        if (m_n >= 4) begin
            s_edge = sq[1] && !sq[0];
            f_edge = fq[1] && !fq[0];
        end else if (m_n == 3) begin
            f_edge = fq[0];
        end
        sq.push_back(start);
        fq.push_back(fire);
        if (sq.size() > 3) void'(sq.pop_front());
        if (fq.size() > 3) void'(fq.pop_front());

        st0 = m_st; fr0 = m_frz; cd0 = m_cd; lv0 = m_lives;
        m_gt = tick && st0 == 1 && fr0 == 0;
        m_bf = 0;
        m_rr = 0;
        if (tick && fr0 > 0) m_frz = fr0 - 1;
        if (tick && cd0 > 0) m_cd = cd0 - 1;
        if (st0 != 1) begin
            m_pend = 0;
            if (s_edge) begin
                m_st = 1;
                m_rr = 1;
                if (st0 == 2) m_level = (m_level < 7) ? m_level + 1 : 7;
                else begin
                    m_lives = SL; m_score = 0; m_level = 0; m_frz = 0; m_cd = 0;
                end
            end
        end else begin
            if (ah) m_score = (m_score < 999) ? m_score + 1 : 999;
            want = m_pend || f_edge;
            if (want && fr0 == 0 && cd0 == 0 && !bo) begin
                m_bf = 1; want = 0; m_cd = FC;
            end
            if (rb || (ph && fr0 == 0 && lv0 == 1)) begin
                m_st = 3; m_lives = 0;
            end else begin
                if (ph && fr0 == 0) begin
                    m_lives = lv0 - 1; m_frz = HF;
                end
                if (ad) m_st = 2;
            end
            m_pend = (m_st == 1) && want;
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_n = 0; m_st = 0; m_lives = 0; m_score = 0; m_level = 0;
            m_frz = 0; m_cd = 0; m_pend = 0; m_gt = 0; m_bf = 0; m_rr = 0;
            sq.delete();
            fq.delete();
        end else begin
            model_step();
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("m.state", st, m_st);
            check("m.lives", lv, m_lives);
            check("m.score", sc, m_score);
            check("m.level", lvl, m_level);
            check("m.game_tick", gt, m_gt);
            check("m.bullet_fired", bf, m_bf);
            check("m.round_reset", rr, m_rr);
        end
    end

    // ---------------- vector table -----------------------------------------
    typedef struct {
        string name;
        int    cycles;
        bit    s, f, a, p, d, r, b;
        int    e_st, e_lives, e_score, e_level;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(string nm, int c, bit s, bit f, bit a, bit p, bit d, bit r,
                                bit b, int es, int el, int esc, int elv);
        vec_t v;
        v.name = nm; v.cycles = c;
        v.s = s; v.f = f; v.a = a; v.p = p; v.d = d; v.r = r; v.b = b;
        v.e_st = es; v.e_lives = el; v.e_score = esc; v.e_level = elv;
        return v;
    endfunction

    task automatic cyc(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".state"}, st, 0);
        check({tag, ".lives"}, lv, 0);
        check({tag, ".score"}, sc, 0);
        check({tag, ".level"}, lvl, 0);
        check({tag, ".game_tick"}, gt, 0);
        check({tag, ".bullet_fired"}, bf, 0);
        check({tag, ".round_reset"}, rr, 0);
    endtask

    initial begin
        int n;
        bit got;

        //                 name          cyc  s f a p d r b   st lv  sc lvl
        tbl.push_back(mk("idle",         6,  0,0,0,0,0,0,0,  0, 0,  0, 0));
        tbl.push_back(mk("start",        3,  1,0,0,0,0,0,0,  1, 3,  0, 0));
        tbl.push_back(mk("alien1",       1,  0,0,1,0,0,0,0,  1, 3,  1, 0));
        tbl.push_back(mk("alien5",       5,  0,0,1,0,0,0,0,  1, 3,  6, 0));
        tbl.push_back(mk("hit1",         1,  0,0,0,1,0,0,0,  1, 2,  6, 0));
        tbl.push_back(mk("hit_frozen",   1,  0,0,0,1,0,0,0,  1, 2,  6, 0));
        tbl.push_back(mk("thaw1",       12,  0,0,0,0,0,0,0,  1, 2,  6, 0));
        tbl.push_back(mk("hit2",         1,  0,0,0,1,0,0,0,  1, 1,  6, 0));
        tbl.push_back(mk("thaw2",       12,  0,0,0,0,0,0,0,  1, 1,  6, 0));
        tbl.push_back(mk("hit_fatal",    1,  0,0,0,1,0,0,0,  3, 0,  6, 0));
        tbl.push_back(mk("lose_alien",   4,  0,0,1,0,0,0,0,  3, 0,  6, 0));
        tbl.push_back(mk("restart",      3,  1,0,0,0,0,0,0,  1, 3,  0, 0));
        tbl.push_back(mk("bottom_win",   1,  0,0,0,0,1,1,0,  3, 0,  0, 0));
        tbl.push_back(mk("restart2",     3,  1,0,0,0,0,0,0,  1, 3,  0, 0));
        tbl.push_back(mk("win",          1,  0,0,0,0,1,0,0,  2, 3,  0, 0));
        tbl.push_back(mk("win_alien",    3,  0,0,1,0,0,0,0,  2, 3,  0, 0));
        tbl.push_back(mk("next_round",   3,  1,0,0,0,0,0,0,  1, 3,  0, 1));
        tbl.push_back(mk("quiet",        2,  0,0,0,0,0,0,0,  1, 3,  0, 1));

        cyc(2);
        check_all_zero("reset");
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            start = tbl[i].s; fire = tbl[i].f; ah = tbl[i].a; ph = tbl[i].p;
            ad = tbl[i].d; rb = tbl[i].r; bo = tbl[i].b;
            cyc(tbl[i].cycles);
            check({tbl[i].name, ".state"}, st, tbl[i].e_st);
            check({tbl[i].name, ".lives"}, lv, tbl[i].e_lives);
            check({tbl[i].name, ".score"}, sc, tbl[i].e_score);
            check({tbl[i].name, ".level"}, lvl, tbl[i].e_level);
        end

        // Movement strobe period in PLAY
        n = 0;
        repeat (16) begin cyc(1); n += int'(gt); end
        check("tick_period", n, 4);

        // First shot, then a quick re-press that must wait out the cooldown
        fire = 1'b1;
        got  = 0;
        for (int k = 0; k < 8 && !got; k++) begin cyc(1); if (bf) got = 1; end
        check("fire1_grant", int'(got), 1);
        fire = 1'b0; cyc(1); fire = 1'b1;
        n = 0;
        repeat (4) begin cyc(1); n += int'(bf); end
        check("fire2_cooldown_block", n, 0);
        n = 0;
        repeat (10) begin cyc(1); n += int'(bf); end
        check("fire2_single_grant", n, 1);

        // Bullet in flight holds the request until it clears
        fire = 1'b0; bo = 1'b1; cyc(10);
        fire = 1'b1;
        n = 0;
        repeat (8) begin cyc(1); n += int'(bf); end
        check("fire_onscreen_block", n, 0);
        bo = 1'b0;
        n = 0;
        repeat (2) begin cyc(1); n += int'(bf); end
        check("fire_after_clear", n, 1);
        fire = 1'b0;

        // Score saturation, win, next round keeps score
        ah = 1'b1; cyc(1002); ah = 1'b0; cyc(1);
        check("score_sat", sc, 999);
        ad = 1'b1; cyc(1); ad = 1'b0;
        check("sat_win.state", st, 2);
        start = 1'b1;
        n = 0;
        repeat (5) begin cyc(1); n += int'(rr); end
        check("round_reset_once", n, 1);
        check("sat_next.state", st, 1);
        check("sat_next.level", lvl, 2);
        check("sat_next.score", sc, 999);
        start = 1'b0;

        // Asynchronous reset mid-play with the freeze running
        ph = 1'b1; cyc(1); ph = 1'b0; cyc(1);
        #2 rst_n = 1'b0;
        #1 check_all_zero("async_reset");
        cyc(2);

        // Start already high at release must not begin a game
        start = 1'b1;
        cyc(1);
        rst_n = 1'b1;
        cyc(8);
        check("held_start.state", st, 0);
        start = 1'b0; cyc(2);
        start = 1'b1; cyc(3);
        check("fresh_start.state", st, 1);

        // Randomised play against the model
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 29) == 0) start = ~start;
            if ($urandom_range(0, 5) == 0) fire = ~fire;
            ah = ($urandom_range(0, 3) == 0);
            ph = ($urandom_range(0, 24) == 0);
            ad = ($urandom_range(0, 59) == 0);
            rb = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 7) == 0) bo = ~bo;
            if ($urandom_range(0, 1499) == 0) begin
                #1 rst_n = 1'b0;
                #2 rst_n = 1'b1;
            end
        end
        cyc(2);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
`default_nettype wire
